// File: rtl/moore_ch_scheduler_pkg.sv
// Shared types and constants for the multi-channel Moore scheduler.
// State encoding is {y1,y2,y3}; y3 is the detection bit.
package moore_ch_scheduler_pkg;
   localparam int STATE_W = 3;
   typedef logic [STATE_W-1:0] state_t;

   localparam state_t STATE_IDLE = 3'b000;
   localparam state_t STATE_DET  = 3'b001;

   localparam int Y1_IDX = 2;
   localparam int Y2_IDX = 1;
   localparam int Y3_IDX = 0;
endpackage

// File: rtl/moore_ch_scheduler_if.sv
// Request/ack and result bus between serial bit sources and the scheduler.
// master: bit sources and status logic; slave: the scheduler.
interface moore_ch_scheduler_if
   import moore_ch_scheduler_pkg::*;
#(
   parameter int NUM_CH = 4
);
   localparam int CH_W = $clog2(NUM_CH);

   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] w;
   logic [NUM_CH-1:0] clr;
   logic [NUM_CH-1:0] ack;
   logic              out_valid;
   logic [CH_W-1:0]   out_ch;
   state_t            out_state;
   logic              out_det;
   logic [NUM_CH-1:0] det_vec;

   modport master (
      output req, w, clr,
      input  ack, out_valid, out_ch, out_state, out_det, det_vec
   );

   modport slave (
      input  req, w, clr,
      output ack, out_valid, out_ch, out_state, out_det, det_vec
   );
endinterface

// File: rtl/moore_ch_scheduler_next_state.sv
// Shared Moore next-state datapath: 3-bit state plus input bit w.
// Purely combinational, zero latency, no flow control.
module moore_ch_scheduler_next_state
   import moore_ch_scheduler_pkg::*;
(
   input  logic   i_w,
   input  state_t i_state,
   output state_t o_next
);
   logic w_y1;
   logic w_y2;
   logic w_y3;

   assign w_y1 = i_state[Y1_IDX];
   assign w_y2 = i_state[Y2_IDX];
   assign w_y3 = i_state[Y3_IDX];

   assign o_next[Y1_IDX] = ~w_y1 & ~w_y3 & (w_y2 ^ i_w);
   assign o_next[Y2_IDX] = (w_y2 & w_y3) | (w_y1 & w_y3) |
                           (i_w & w_y1 & ~w_y2) | (w_y2 & ~w_y1 & ~i_w);
   // y3 alone keeps the state sticky once detection has occurred
   assign o_next[Y3_IDX] = w_y3 | (w_y1 & w_y2 & i_w);
endmodule

// File: rtl/moore_ch_scheduler.sv
// Round-robin shares one Moore datapath across NUM_CH channels; ack is same-cycle, result 1 cycle later.
// A channel holds req/w until acked; cleared channels sit out arbitration for that cycle.
module moore_ch_scheduler
   import moore_ch_scheduler_pkg::*;
#(
   parameter int NUM_CH = 4
)(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   moore_ch_scheduler_if.slave  bus
);
   localparam int              CH_W     = $clog2(NUM_CH);
   localparam logic [CH_W:0]   NUM_CH_X = (CH_W+1)'(NUM_CH);
   localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

   logic [NUM_CH-1:0] w_elig;
   logic [NUM_CH-1:0] w_ack;
   logic              w_grant_vld;
   logic [CH_W-1:0]   w_grant_ch;
   logic [CH_W-1:0]   w_ptr_nxt;
   state_t            w_cur;
   logic              w_cur_w;
   state_t            w_nxt;
   state_t            w_state_nxt [NUM_CH];

   logic [CH_W-1:0]   r_ptr;
   state_t            r_state [NUM_CH];
   logic              r_out_valid;
   logic [CH_W-1:0]   r_out_ch;
   state_t            r_out_state;
   logic              r_out_det;
   logic [NUM_CH-1:0] r_det_vec;

   assign w_elig = bus.req & ~bus.clr;

   // Cyclic first-eligible search starting at the pointer
   always_comb begin
      logic [CH_W:0] v_idx;
      w_grant_vld = 1'b0;
      w_grant_ch  = '0;
      v_idx       = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         v_idx = {1'b0, r_ptr} + (CH_W+1)'(k);
         if (v_idx >= NUM_CH_X) v_idx = v_idx - NUM_CH_X;
         if (!w_grant_vld && w_elig[v_idx[CH_W-1:0]]) begin
            w_grant_vld = 1'b1;
            w_grant_ch  = v_idx[CH_W-1:0];
         end
      end
   end

   always_comb begin
      w_ack = '0;
      if (i_rst_n && w_grant_vld) w_ack[w_grant_ch] = 1'b1;
   end

   assign w_ptr_nxt = (w_grant_ch == LAST_CH) ? '0 : w_grant_ch + CH_W'(1);
   assign w_cur     = r_state[w_grant_ch];
   assign w_cur_w   = bus.w[w_grant_ch];

   moore_ch_scheduler_next_state u_next_state (
      .i_w     (w_cur_w),
      .i_state (w_cur),
      .o_next  (w_nxt)
   );

   // A granted channel is never cleared, so the two updates cannot collide
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         w_state_nxt[i] = r_state[i];
         if (bus.clr[i])
            w_state_nxt[i] = STATE_IDLE;
         else if (w_grant_vld && (w_grant_ch == CH_W'(i)))
            w_state_nxt[i] = w_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_ptr       <= '0;
         r_out_valid <= 1'b0;
         r_out_ch    <= '0;
         r_out_state <= STATE_IDLE;
         r_out_det   <= 1'b0;
         r_det_vec   <= '0;
         for (int i = 0; i < NUM_CH; i++) r_state[i] <= STATE_IDLE;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_state[i]   <= w_state_nxt[i];
            r_det_vec[i] <= w_state_nxt[i][Y3_IDX];
         end
         r_out_valid <= w_grant_vld;
         if (w_grant_vld) begin
            r_ptr       <= w_ptr_nxt;
            r_out_ch    <= w_grant_ch;
            r_out_state <= w_nxt;
            r_out_det   <= w_nxt[Y3_IDX];
         end
      end
   end

   assign bus.ack       = w_ack;
   assign bus.out_valid = r_out_valid;
   assign bus.out_ch    = r_out_ch;
   assign bus.out_state = r_out_state;
   assign bus.out_det   = r_out_det;
   assign bus.det_vec   = r_det_vec;
endmodule
